// File: rtl/run_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : run_controller_pkg
// Brief    : State encoding, fail codes and width helper for run_controller.
// Revision : 1.0 - initial release
// ============================================================================
package run_controller_pkg;

    localparam int STATE_W = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HOLD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_HALTED = 3'd3;
    localparam logic [2:0] ST_FAILED = 3'd4;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_HANG    = 2'b10;

    // Bits needed to hold every value 0..limit, never less than one.
    function automatic int cnt_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/run_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Up-counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// Module   : run_controller
// Brief    : Holds a CPU in reset, runs it, and ends the run on halt/hang/timeout.
// Revision : 1.0 - initial release
// ============================================================================
module run_controller
    import run_controller_pkg::*;
#(
    parameter int RST_CYCLES = 4,
    parameter int MAX_CYCLES = 100000,
    parameter int IDLE_LIMIT = 64,
    parameter int LOOP_LIMIT = 3,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             retire_valid,
    input  logic [31:0]      retire_pc,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             fail,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam int HOLD_W = cnt_width(RST_CYCLES);
    localparam int IDLE_W = cnt_width(IDLE_LIMIT);
    localparam int LOOP_W = cnt_width(LOOP_LIMIT);
    localparam int CMP_W  = ((CNT_W > 32) ? CNT_W : 32) + 1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [LOOP_W-1:0]  loop_q, loop_d, loop_nxt;
    logic [31:0]        prev_pc_q, prev_pc_d;
    logic               have_prev_q, have_prev_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               in_run, start_acc, retire_run;
    logic               halt_hit, hang_hit, timeout_hit;

    assign in_run     = (state_q == ST_RUN);
    assign start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_HALTED) ||
                                  (state_q == ST_FAILED));
    assign retire_run = in_run && retire_valid;

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc),
        .inc_i (in_run),
        .cnt_o (cycle_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc),
        .inc_i (retire_run),
        .cnt_o (instr_cnt)
    );

    sat_counter #(.WIDTH(IDLE_W)) u_idle_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (start_acc || retire_run),
        .inc_i (in_run && !retire_valid),
        .cnt_o (idle_cnt)
    );

    // The first retirement has no predecessor, so it always opens a fresh run of length 1.
    assign loop_nxt = (have_prev_q && (retire_pc == prev_pc_q)) ? loop_q + LOOP_W'(1)
                                                                : LOOP_W'(1);

    assign halt_hit    = retire_run && (int'(loop_nxt) == LOOP_LIMIT);
    assign hang_hit    = in_run && !retire_valid && (int'(idle_cnt) == IDLE_LIMIT - 1);
    // A saturated cycle counter can never reach a budget beyond its range.
    assign timeout_hit = in_run && !(&cycle_cnt) &&
                         ((CMP_W'(cycle_cnt) + CMP_W'(1)) == CMP_W'($unsigned(MAX_CYCLES)));

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        loop_d      = loop_q;
        prev_pc_d   = prev_pc_q;
        have_prev_d = have_prev_q;
        done_d      = done_q;
        fail_d      = fail_q;
        fail_code_d = fail_code_q;
        case (state_q)
            ST_IDLE, ST_HALTED, ST_FAILED: begin
                if (start) begin
                    state_d     = ST_HOLD;
                    hold_d      = '0;
                    loop_d      = '0;
                    have_prev_d = 1'b0;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    fail_code_d = FC_NONE;
                end
            end
            ST_HOLD: begin
                if (int'(hold_q) == RST_CYCLES - 1) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (retire_valid) begin
                    prev_pc_d   = retire_pc;
                    have_prev_d = 1'b1;
                    loop_d      = loop_nxt;
                end
                if (halt_hit) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (hang_hit) begin
                    state_d     = ST_FAILED;
                    fail_d      = 1'b1;
                    fail_code_d = FC_HANG;
                end else if (timeout_hit) begin
                    state_d     = ST_FAILED;
                    fail_d      = 1'b1;
                    fail_code_d = FC_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            loop_q      <= '0;
            prev_pc_q   <= '0;
            have_prev_q <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_code_q <= FC_NONE;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            loop_q      <= loop_d;
            prev_pc_q   <= prev_pc_d;
            have_prev_q <= have_prev_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            fail_code_q <= fail_code_d;
        end
    end

    assign cpu_reset = !in_run;
    assign running   = in_run;
    assign done      = done_q;
    assign fail      = fail_q;
    assign fail_code = fail_code_q;

endmodule
`default_nettype wire
